// File: rtl/pigro_trace_buf.sv
// pigro_trace_buf: triggered circular capture of writeback records, drained oldest-first over valid/ready.
module pigro_trace_buf #(
  parameter int DATA_W = 32,
  parameter int OP_W = 5,
  parameter int PC_W = 5,
  parameter int RA_W = 4,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int RW = 2*DATA_W + OP_W + PC_W + RA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [OP_W-1:0]   trig_op,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_aluout,
  input  logic [DATA_W-1:0] wb_lmdout,
  input  logic [OP_W-1:0]   wb_opcode,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic              wb_e,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [RW-1:0]     rd_data,
  output logic              rd_last,
  output logic [1:0]        state,
  output logic [CW-1:0]     count,
  output logic [AW-1:0]     trig_idx
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, post_cnt, wp_n, ti_n;
  logic [CW-1:0] remaining, cnt_n;
  logic [1:0] nxt;
  logic wrapped, wrap_n, clr, wr_en, hit, trig, xfer;

  always_comb begin
    clr = arm && state != DONE;
    wr_en = (state == ARMED || state == POST) && wb_valid && !arm;
    hit = trig_mode == 2'd0 ? 1'b1 :
          trig_mode == 2'd1 ? wb_opcode == trig_op :
          trig_mode == 2'd2 ? wb_pc == trig_pc : wb_e;
    trig = state == ARMED && wr_en && hit;
    xfer = rd_valid && rd_ready;
    wp_n = wr_ptr + 1'b1;
    wrap_n = wrapped || &wr_ptr;
    cnt_n = count == CW'(DEPTH) ? count : count + 1'b1;
    ti_n = AW'(cnt_n - CW'(1) - CW'(POST_TRIG));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state == IDLE ? (arm ? ARMED : IDLE) :
          state == DONE ? (xfer && rd_last ? IDLE : DONE) :
          arm ? ARMED :
          trig ? (POST_TRIG == 0 ? DONE : POST) :
          state == POST && wr_en && post_cnt == AW'(1) ? DONE : state;
  end

  always_comb begin
    rd_valid = state == DONE && remaining != '0;
    rd_last = rd_valid && remaining == CW'(1);
    rd_data = rd_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      post_cnt <= '0;
      count <= '0;
      remaining <= '0;
      trig_idx <= '0;
      wrapped <= 1'b0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        count <= '0;
        wrapped <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wp_n;
        count <= cnt_n;
        wrapped <= wrap_n;
      end
      if (trig) post_cnt <= AW'(POST_TRIG);
      else if (wr_en && state == POST) post_cnt <= post_cnt - 1'b1;
      // DONE is only ever entered on a capturing edge, so the *_n values describe the final window
      if (nxt == DONE && state != DONE) begin
        rd_ptr <= wrap_n ? wp_n : '0;
        remaining <= cnt_n;
        trig_idx <= ti_n;
      end else if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {wb_aluout, wb_lmdout, wb_opcode, wb_pc, wb_dest, wb_e};
endmodule

// File: tb/tb_pigro_trace_buf.sv
// tb_pigro_trace_buf: directed scoreboard bench; one instance with POST_TRIG=8, one with POST_TRIG=0.
module tb_pigro_trace_buf;
  localparam int RW = 79;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, wb_valid = 1'b0, wb_e = 1'b0, rd_ready = 1'b0, sel = 1'b0;
  logic [1:0] trig_mode = '0;
  logic [4:0] trig_op = '0, trig_pc = '0, wb_opcode = '0, wb_pc = '0;
  logic [31:0] wb_aluout = '0, wb_lmdout = '0;
  logic [3:0] wb_dest = '0;
  logic rv0, rv1, rl0, rl1;
  logic [RW-1:0] rd0, rd1;
  logic [1:0] st0, st1;
  logic [4:0] c0, c1;
  logic [3:0] ti0, ti1;
  logic o_valid, o_last;
  logic [RW-1:0] o_data;
  logic [1:0] o_state;
  logic [4:0] o_count;
  logic [3:0] o_tidx;
  logic [RW-1:0] exp_q [$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pigro_trace_buf #(.POST_TRIG(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm & ~sel), .trig_mode(trig_mode), .trig_op(trig_op), .trig_pc(trig_pc),
    .wb_valid(wb_valid), .wb_aluout(wb_aluout), .wb_lmdout(wb_lmdout), .wb_opcode(wb_opcode), .wb_pc(wb_pc),
    .wb_dest(wb_dest), .wb_e(wb_e), .rd_ready(rd_ready & ~sel), .rd_valid(rv0), .rd_data(rd0), .rd_last(rl0),
    .state(st0), .count(c0), .trig_idx(ti0));

  pigro_trace_buf #(.POST_TRIG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm & sel), .trig_mode(trig_mode), .trig_op(trig_op), .trig_pc(trig_pc),
    .wb_valid(wb_valid), .wb_aluout(wb_aluout), .wb_lmdout(wb_lmdout), .wb_opcode(wb_opcode), .wb_pc(wb_pc),
    .wb_dest(wb_dest), .wb_e(wb_e), .rd_ready(rd_ready & sel), .rd_valid(rv1), .rd_data(rd1), .rd_last(rl1),
    .state(st1), .count(c1), .trig_idx(ti1));

  assign o_valid = sel ? rv1 : rv0;
  assign o_last = sel ? rl1 : rl0;
  assign o_data = sel ? rd1 : rd0;
  assign o_state = sel ? st1 : st0;
  assign o_count = sel ? c1 : c0;
  assign o_tidx = sel ? ti1 : ti0;

  function automatic logic [RW-1:0] mk(input int i, input logic e);
    logic [31:0] a = 32'hA500_0000 + 32'(i);
    logic [31:0] l = ~(32'h0000_1000 + 32'(i));
    return {a, l, 5'(i) ^ 5'h15, 5'(i), 4'(i * 3), e};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic e, input bit keep);
    wb_valid = 1'b1;
    {wb_aluout, wb_lmdout, wb_opcode, wb_pc, wb_dest, wb_e} = mk(i, e);
    if (keep) exp_q.push_back(mk(i, e));
  endtask

  task automatic do_arm(input logic [1:0] mode);
    trig_mode = mode;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic drain(input bit bp);
    logic [RW-1:0] held = '0;
    logic [RW-1:0] e;
    bit hv = 0;
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      rd_ready = bp ? cyc[0] : 1'b1;
      #1;
      if (hv) chk("stall_stable", o_data, held);
      hv = 0;
      if (o_valid && rd_ready) begin
        e = exp_q.pop_front();
        chk("rd_data", o_data, e);
        chk("rd_last", o_last, 1'(exp_q.size() == 0));
      end else if (o_valid) begin
        held = o_data;
        hv = 1;
      end
      tick;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      arm = 1'($urandom);
      wb_valid = 1'($urandom);
      wb_aluout = $urandom;
      trig_mode = 2'($urandom);
      tick;
    end
    chk("rst_state", o_state, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_data", o_data, 0);
    chk("rst_tidx", o_tidx, 0);
    arm = 1'b0;
    wb_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    // immediate trigger; the record coincident with arm in IDLE must be dropped
    drive(31, 1'b0, 0);
    do_arm(2'd0);
    chk("arm_idle_state", o_state, 1);
    chk("arm_idle_count", o_count, 0);
    for (int i = 0; i < 20; i++) begin
      drive(i, 1'b0, i < 9);
      tick;
      if (i == 0) chk("imm_post", o_state, 2);
      if (i == 8) chk("imm_done", o_state, 3);
    end
    wb_valid = 1'b0;
    chk("imm_count", o_count, 9);
    chk("imm_tidx", o_tidx, 0);
    chk("imm_valid", o_valid, 1);
    drain(0);
    chk("imm_idle", o_state, 0);
    // wrapped window with PC trigger, drained under backpressure
    trig_pc = 5'd20;
    do_arm(2'd2);
    for (int i = 0; i < 40; i++) begin
      drive(i, 1'b0, i >= 13 && i <= 28);
      tick;
      if (i == 19) chk("pc_armed", o_state, 1);
      if (i == 20) chk("pc_post", o_state, 2);
      if (i == 27) chk("pc_post_late", o_state, 2);
      if (i == 28) chk("pc_done", o_state, 3);
    end
    wb_valid = 1'b0;
    chk("wrap_count", o_count, 16);
    chk("wrap_tidx", o_tidx, 7);
    drain(1);
    chk("wrap_idle", o_state, 0);
    // error trigger on the POST_TRIG=0 instance
    sel = 1'b1;
    #1;
    do_arm(2'd3);
    for (int i = 0; i < 7; i++) begin
      drive(i, 1'(i == 4), i < 5);
      tick;
      if (i == 3) chk("err_armed", o_state, 1);
      if (i == 4) chk("err_done", o_state, 3);
    end
    wb_valid = 1'b0;
    chk("err_count", o_count, 5);
    chk("err_tidx", o_tidx, 4);
    chk("err_last_e", exp_q[exp_q.size() - 1][0], 1);
    drain(0);
    chk("err_idle", o_state, 0);
    sel = 1'b0;
    #1;
    // arm during POST restarts and drops the coincident record
    do_arm(2'd0);
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 0);
      tick;
    end
    chk("restart_pre", o_state, 2);
    drive(9, 1'b0, 0);
    trig_mode = 2'd1;
    trig_op = 5'd5 ^ 5'h15;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    chk("restart_state", o_state, 1);
    chk("restart_count", o_count, 0);
    for (int i = 0; i < 16; i++) begin
      drive(i, 1'b0, i < 14);
      tick;
      if (i == 4) chk("op_armed", o_state, 1);
      if (i == 5) chk("op_post", o_state, 2);
    end
    wb_valid = 1'b0;
    chk("op_done", o_state, 3);
    chk("op_count", o_count, 14);
    chk("op_tidx", o_tidx, 5);
    // arm in DONE is ignored
    arm = 1'b1;
    tick;
    arm = 1'b0;
    chk("done_arm_state", o_state, 3);
    chk("done_arm_count", o_count, 14);
    drain(0);
    chk("op_idle", o_state, 0);
    // asynchronous reset mid-readout
    do_arm(2'd0);
    for (int i = 0; i < 9; i++) begin
      drive(i, 1'b0, 0);
      tick;
    end
    wb_valid = 1'b0;
    chk("ar_done", o_state, 3);
    rd_ready = 1'b1;
    tick;
    tick;
    rd_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", o_state, 0);
    chk("ar_valid", o_valid, 0);
    chk("ar_count", o_count, 0);
    chk("ar_data", o_data, 0);
    chk("ar_tidx", o_tidx, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("ar_after", o_state, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
